etap_host_driver: RTL and testbench

//  Host-side JTAG initiator for the EJTAG TAP: the opposite end of the TAP instruction path.

---
 rtl/etap_host_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_etap_host_driver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etap_host_driver.sv
// Host-side JTAG initiator for the EJTAG TAP: walks the TAP state machine,
// shifts one instruction and an optional data payload, and returns the captured TDO words.
module etap_host_driver #(
  parameter int IR_W = 5,
  parameter int DR_W = 32,
  parameter int DIV  = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [IR_W-1:0]             cmd_ir,
  input  logic [DR_W-1:0]             cmd_dr,
  input  logic [$clog2(DR_W+1)-1:0]   cmd_dr_len,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IR_W-1:0]             rsp_ir,
  output logic [DR_W-1:0]             rsp_dr,
  output logic                        busy,
  output logic                        tck,
  output logic                        tms,
  output logic                        tdi,
  input  logic                        tdo
);

  localparam int LEN_W = $clog2(DR_W + 1);
  localparam int CNT_W = (2 * DIV > 2) ? $clog2(2 * DIV) : 1;
  localparam int IDX_W = $clog2(DR_W + IR_W + 8);
  localparam int IRI_W = (IR_W > 1) ? $clog2(IR_W) : 1;
  localparam int DRI_W = (DR_W > 1) ? $clog2(DR_W) : 1;

  typedef enum logic [3:0] {
    TLR_SEQ  = 4'd0,
    IDLE     = 4'd1,
    IR_PRE   = 4'd2,
    IR_SHIFT = 4'd3,
    IR_POST  = 4'd4,
    DR_PRE   = 4'd5,
    DR_SHIFT = 4'd6,
    DR_POST  = 4'd7,
    RESP     = 4'd8
  } state_e;

  // Index of the final tick spent in a given state.
  function automatic logic [IDX_W-1:0] last_tick(input state_e st, input logic [LEN_W-1:0] len);
    logic [IDX_W-1:0] r;
    case (st)
      TLR_SEQ:  r = IDX_W'(5);
      IR_PRE:   r = IDX_W'(3);
      IR_SHIFT: r = IDX_W'(IR_W - 1);
      IR_POST:  r = (len == '0) ? IDX_W'(1) : '0;
      DR_PRE:   r = IDX_W'(2);
      DR_SHIFT: r = IDX_W'(len) - IDX_W'(1);
      DR_POST:  r = IDX_W'(1);
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic state_e next_phase(input state_e st, input logic [LEN_W-1:0] len);
    state_e r;
    case (st)
      TLR_SEQ:  r = IDLE;
      IR_PRE:   r = IR_SHIFT;
      IR_SHIFT: r = IR_POST;
      IR_POST:  r = (len == '0) ? RESP : DR_PRE;
      DR_PRE:   r = DR_SHIFT;
      DR_SHIFT: r = DR_POST;
      DR_POST:  r = RESP;
      default:  r = IDLE;
    endcase
    return r;
  endfunction

  function automatic logic tms_for(input state_e st, input logic [IDX_W-1:0] idx,
                                   input logic [LEN_W-1:0] len);
    logic r;
    case (st)
      TLR_SEQ:            r = (idx != last_tick(st, len));
      IR_PRE:             r = (idx < IDX_W'(2));
      IR_SHIFT, DR_SHIFT: r = (idx == last_tick(st, len));
      IR_POST, DR_PRE,
      DR_POST:            r = (idx == '0);
      IDLE, RESP:         r = 1'b0;
      default:            r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic tdi_for(input state_e st, input logic [IDX_W-1:0] idx,
                                   input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr);
    logic r;
    case (st)
      IR_SHIFT: r = ir[idx[IRI_W-1:0]];
      DR_SHIFT: r = dr[idx[DRI_W-1:0]];
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IR_W-1:0]   ir_q, ir_d, ir_cap_q, ir_cap_d, rsp_ir_q, rsp_ir_d;
  logic [DR_W-1:0]   dr_q, dr_d, dr_cap_q, dr_cap_d, rsp_dr_q, rsp_dr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic              busy_q, busy_d, cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic              ticking_s, tick_end_s, sample_s, accept_s, rsp_done_s;

  assign ticking_s  = (state_q != IDLE) && (state_q != RESP);
  assign tick_end_s = (cnt_q == CNT_W'(2 * DIV - 1));
  assign sample_s   = (cnt_q == CNT_W'(DIV - 1));
  assign accept_s   = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign rsp_done_s = (state_q == RESP) && rsp_valid_q && rsp_ready;

  // State register and registered outputs; reset parks the pins for a TLR walk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= TLR_SEQ;
      idx_q       <= '0;
      cnt_q       <= '0;
      ir_q        <= '0;
      dr_q        <= '0;
      len_q       <= '0;
      ir_cap_q    <= '0;
      dr_cap_q    <= '0;
      rsp_ir_q    <= '0;
      rsp_dr_q    <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      busy_q      <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ir_q        <= ir_d;
      dr_q        <= dr_d;
      len_q       <= len_d;
      ir_cap_q    <= ir_cap_d;
      dr_cap_q    <= dr_cap_d;
      rsp_ir_q    <= rsp_ir_d;
      rsp_dr_q    <= rsp_dr_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next state: tick sequencing, command latch and TDO capture on the tck rising edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    dr_d     = dr_q;
    len_d    = len_q;
    ir_cap_d = ir_cap_q;
    dr_cap_d = dr_cap_q;
    if (ticking_s) begin
      if (tick_end_s) begin
        cnt_d = '0;
        if (idx_q == last_tick(state_q, len_q)) begin
          idx_d   = '0;
          state_d = next_phase(state_q, len_q);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (sample_s && (state_q == IR_SHIFT)) begin
        ir_cap_d[idx_q[IRI_W-1:0]] = tdo;
      end else if (sample_s && (state_q == DR_SHIFT)) begin
        dr_cap_d[idx_q[DRI_W-1:0]] = tdo;
      end else begin
        ir_cap_d = ir_cap_q;
      end
    end else if (accept_s) begin
      state_d  = IR_PRE;
      idx_d    = '0;
      cnt_d    = '0;
      ir_d     = cmd_ir;
      dr_d     = cmd_dr;
      len_d    = (cmd_dr_len > LEN_W'(DR_W)) ? LEN_W'(DR_W) : cmd_dr_len;
      ir_cap_d = '0;
      dr_cap_d = '0;
    end else if (rsp_done_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Output decode from the upcoming state so pins change only at the start of a low phase.
  always_comb begin
    tck_d       = (cnt_d >= CNT_W'(DIV));
    tms_d       = tms_for(state_d, idx_d, len_d);
    tdi_d       = tdi_for(state_d, idx_d, ir_d, dr_d);
    busy_d      = (state_d != IDLE) && (state_d != RESP);
    cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    if ((state_q != RESP) && (state_d == RESP)) begin
      rsp_ir_d = ir_cap_q;
      rsp_dr_d = dr_cap_q;
    end else begin
      rsp_ir_d = rsp_ir_q;
      rsp_dr_d = rsp_dr_q;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ir    = rsp_ir_q;
  assign rsp_dr    = rsp_dr_q;
  assign busy      = busy_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_etap_host_driver.sv
// Scoreboard bench for etap_host_driver with a behavioural EJTAG TAP on the JTAG pins.
module tb_etap_host_driver;

  localparam int IR_W = 5;
  localparam int DR_W = 32;
  localparam int DIV  = 2;
  localparam int LEN_W = 6;

  localparam logic [3:0] S_TLR = 4'd0, S_RTI = 4'd1, S_SELDR = 4'd2, S_CAPDR = 4'd3,
                         S_SHDR = 4'd4, S_EX1DR = 4'd5, S_PDR = 4'd6, S_EX2DR = 4'd7,
                         S_UPDDR = 4'd8, S_SELIR = 4'd9, S_CAPIR = 4'd10, S_SHIR = 4'd11,
                         S_EX1IR = 4'd12, S_PIR = 4'd13, S_EX2IR = 4'd14, S_UPDIR = 4'd15;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir = '0;
  logic [DR_W-1:0]   cmd_dr = '0;
  logic [LEN_W-1:0]  cmd_dr_len = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IR_W-1:0]   rsp_ir;
  logic [DR_W-1:0]   rsp_dr;
  logic              busy, tck, tms, tdi;
  logic              tdo = 1'b0;

  int checks = 0;
  int failures = 0;
  int tick_n = 0;
  int resp_count = 0;
  logic tms_all [0:1023];
  logic tdi_all [0:1023];
  logic [IR_W+DR_W-1:0] exp_q [$];

  logic [3:0]  tap_st = S_TLR;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  tap_ir_sr = 5'h00;
  logic [31:0] tap_dr_sr = 32'h0;
  logic        tap_byp = 1'b0;

  always #5 clk = ~clk;

  etap_host_driver #(.IR_W(IR_W), .DR_W(DR_W), .DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_dr_len(cmd_dr_len), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_ir(rsp_ir), .rsp_dr(rsp_dr), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_bits(input int base, input int n, input bit use_tdi);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n && i < 64 && base + i < 1024; i++)
      r[i] = use_tdi ? tdi_all[base + i] : tms_all[base + i];
    return r;
  endfunction

  // Record tms/tdi as the target sees them on each tck rising edge.
  initial forever begin
    @(posedge tck);
    if (tick_n < 1024) begin
      tms_all[tick_n] = tms;
      tdi_all[tick_n] = tdi;
    end
    tick_n = tick_n + 1;
  end

  // Behavioural TAP: acts and moves on tck rise, drives tdo on tck fall.
  initial forever begin
    @(posedge tck);
    case (tap_st)
      S_TLR:   tap_ir = 5'h01;
      S_CAPIR: tap_ir_sr = 5'b00001;
      S_SHIR:  tap_ir_sr = {tdi, tap_ir_sr[4:1]};
      S_UPDIR: tap_ir = tap_ir_sr;
      S_CAPDR: begin
        if (tap_ir == 5'h1F) tap_byp = 1'b0;
        else if (tap_ir == 5'h01) tap_dr_sr = 32'h12345677;
        else tap_dr_sr = 32'h0;
      end
      S_SHDR: begin
        if (tap_ir == 5'h1F) tap_byp = tdi;
        else tap_dr_sr = {tdi, tap_dr_sr[31:1]};
      end
      default: ;
    endcase
    case (tap_st)
      S_TLR:   tap_st = tms ? S_TLR : S_RTI;
      S_RTI:   tap_st = tms ? S_SELDR : S_RTI;
      S_SELDR: tap_st = tms ? S_SELIR : S_CAPDR;
      S_CAPDR: tap_st = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  tap_st = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: tap_st = tms ? S_UPDDR : S_PDR;
      S_PDR:   tap_st = tms ? S_EX2DR : S_PDR;
      S_EX2DR: tap_st = tms ? S_UPDDR : S_SHDR;
      S_UPDDR: tap_st = tms ? S_SELDR : S_RTI;
      S_SELIR: tap_st = tms ? S_TLR : S_CAPIR;
      S_CAPIR: tap_st = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  tap_st = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: tap_st = tms ? S_UPDIR : S_PIR;
      S_PIR:   tap_st = tms ? S_EX2IR : S_PIR;
      S_EX2IR: tap_st = tms ? S_UPDIR : S_SHIR;
      default: tap_st = tms ? S_SELDR : S_RTI;
    endcase
  end

  initial forever begin
    @(negedge tck);
    if (tap_st == S_SHIR) tdo = tap_ir_sr[0];
    else if (tap_st == S_SHDR) tdo = (tap_ir == 5'h1F) ? tap_byp : tap_dr_sr[0];
    else tdo = 1'b0;
  end

  // Scoreboard monitor: compares every response handed over against the queue head.
  initial forever begin
    logic [IR_W+DR_W-1:0] e;
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp got ir=%0h dr=%0h expected none", rsp_ir, rsp_dr);
      end else begin
        e = exp_q.pop_front();
        check("rsp_ir", 64'(rsp_ir), 64'(e[IR_W+DR_W-1:DR_W]));
        check("rsp_dr", 64'(rsp_dr), 64'(e[DR_W-1:0]));
      end
      resp_count = resp_count + 1;
    end
  end

  task automatic tlr_check(input string tag);
    int cyc;
    int base;
    cyc = 0;
    base = tick_n;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (!busy) break;
    end
    check({tag, "_cycles"}, 64'(cyc), 64'd24);
    check({tag, "_ticks"}, 64'(tick_n - base), 64'd6);
    check({tag, "_tms"}, pack_bits(base, 6, 1'b0), 64'h1F);
    check({tag, "_tap_rti"}, 64'(tap_st), 64'(S_RTI));
    @(posedge clk);
    #1;
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic issue(input logic [4:0] ir, input logic [31:0] dr, input logic [5:0] len,
                       input bit push, input logic [4:0] e_ir, input logic [31:0] e_dr);
    int cyc;
    cyc = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_dr_len = len;
    while (cyc < 100) begin
      @(negedge clk);
      if (cmd_ready) break;
      cyc++;
    end
    check("cmd_accept", 64'(cmd_ready), 64'd1);
    if (push) exp_q.push_back({e_ir, e_dr});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_ir = 5'h0A;
    cmd_dr = 32'hFFFF_FFFF;
    cmd_dr_len = 6'd3;
  endtask

  task automatic do_cmd(input string tag, input logic [4:0] ir, input logic [31:0] dr,
                        input logic [5:0] len, input logic [4:0] e_ir, input logic [31:0] e_dr,
                        input int e_ticks, input logic [63:0] e_tms, input logic [63:0] e_tdi);
    int base;
    int rc;
    int cyc;
    base = tick_n;
    rc = resp_count;
    cyc = 0;
    issue(ir, dr, len, 1'b1, e_ir, e_dr);
    while (resp_count == rc && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_rsp_seen"}, 64'(resp_count - rc), 64'd1);
    check({tag, "_ticks"}, 64'(tick_n - base), 64'(e_ticks));
    check({tag, "_tms"}, pack_bits(base, e_ticks, 1'b0), e_tms);
    check({tag, "_tdi"}, pack_bits(base, e_ticks, 1'b1), e_tdi);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL global_timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base;
    int rc;
    int cyc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_word", 64'({rsp_ir, rsp_dr}), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    resetn = 1'b1;
    tlr_check("tlr1");

    // IR-only IDCODE select: 11 ticks
    do_cmd("ir_only", 5'h01, 32'h0, 6'd0, 5'h01, 32'h0, 11, 64'h303, 64'h10);
    // IDCODE read: 47 ticks
    do_cmd("idcode", 5'h01, 32'h0, 6'd32, 5'h01, 32'h12345677, 47, 64'h3000_0000_0703, 64'h10);
    check("tap_ir_upd", 64'(tap_ir), 64'h01);
    // BYPASS echo of A5 delayed by one bit
    do_cmd("bypass", 5'h1F, 32'h0000_00A5, 6'd8, 5'h01, 32'h0000_004A, 23, 64'h30_0703, 64'h14A1F0);
    // Over-long length clamps to 32
    do_cmd("clamp", 5'h01, 32'hFFFF_FFFF, 6'd40, 5'h01, 32'h12345677, 47,
           64'h3000_0000_0703, 64'h1FFF_FFFF_E010);

    // Response back-pressure
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    base = tick_n;
    rc = resp_count;
    issue(5'h1F, 32'h0000_00A5, 6'd8, 1'b1, 5'h01, 32'h0000_004A);
    cyc = 0;
    while (!rsp_valid && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_ir = 5'h03;
      cmd_dr_len = 6'd4;
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_rsp_dr", 64'(rsp_dr), 64'h4A);
      check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    check("stall_no_ticks", 64'(tick_n - base), 64'd23);
    check("stall_no_rsp_yet", 64'(resp_count - rc), 64'd0);
    rsp_ready = 1'b1;
    cyc = 0;
    while (resp_count == rc && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    check("stall_rsp_seen", 64'(resp_count - rc), 64'd1);

    // Reset in the middle of a DR shift drops the command
    base = tick_n;
    issue(5'h01, 32'h0, 6'd32, 1'b0, 5'h00, 32'h0);
    cyc = 0;
    while (tick_n < base + 20 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    rc = resp_count;
    resetn = 1'b0;
    #1;
    check("midrst_tck", 64'(tck), 64'd0);
    check("midrst_tms", 64'(tms), 64'd1);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    tlr_check("tlr2");
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_rsp", 64'(resp_count - rc), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
